// File: rtl/tictactoe_o_player.sv
// tictactoe_o_player: automatic O opponent for the tic-tac-toe datapath.
// When it is O's turn it searches one square per cycle in three passes
// (take a win, block an X win, then a fixed preference order), presents a
// registered one-hot o_move and holds it until the board shows it committed
// or the hold timeout expires.
//
// Optional build macro TTT_OPP_STATS_EN adds a moves_made counter output.
//
// Handshake: o_move/move_valid are a producer-held proposal. Once presented,
// o_move stays stable until the consumer commits it, which is observed as
// (o & o_move) != 0; the move is then withdrawn on the next edge.
module tictactoe_o_player #(
  parameter int HOLD_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [8:0] x,
  input  logic [8:0] o,
  input  logic       winner,
  output logic [8:0] o_move,
  output logic       move_valid,
  output logic       busy,
`ifdef TTT_OPP_STATS_EN
  output logic [3:0] moves_made,
`endif
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SCAN_WIN   = 3'd1,
    SCAN_BLOCK = 3'd2,
    SCAN_PREF  = 3'd3,
    PRESENT    = 3'd4
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_TIMEOUT - 1);

  state_t     state, state_n;
  logic [3:0] idx, idx_n;
  logic [3:0] hold_cnt, hold_n;
  logic [8:0] o_move_n;

  logic [8:0] occ;
  logic [3:0] sq;
  logic       sq_free;
  logic       o_turn;
  logic       accept;

  function automatic logic [3:0] pop9(input logic [8:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 9; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

  // True when some line through square s has both other squares set in b.
  function automatic logic line_hit(input logic [8:0] b, input logic [3:0] s);
    logic h;
    case (s)
      4'd0:    h = (b[1] & b[2]) | (b[3] & b[6]) | (b[4] & b[8]);
      4'd1:    h = (b[0] & b[2]) | (b[4] & b[7]);
      4'd2:    h = (b[0] & b[1]) | (b[5] & b[8]) | (b[4] & b[6]);
      4'd3:    h = (b[4] & b[5]) | (b[0] & b[6]);
      4'd4:    h = (b[3] & b[5]) | (b[1] & b[7]) | (b[0] & b[8]) | (b[2] & b[6]);
      4'd5:    h = (b[3] & b[4]) | (b[2] & b[8]);
      4'd6:    h = (b[7] & b[8]) | (b[0] & b[3]) | (b[2] & b[4]);
      4'd7:    h = (b[6] & b[8]) | (b[1] & b[4]);
      4'd8:    h = (b[6] & b[7]) | (b[2] & b[5]) | (b[0] & b[4]);
      default: h = 1'b0;
    endcase
    return h;
  endfunction

  // Preference order: centre, corners, then edges.
  function automatic logic [3:0] pref_sq(input logic [3:0] p);
    logic [3:0] s;
    case (p)
      4'd0:    s = 4'd4;
      4'd1:    s = 4'd0;
      4'd2:    s = 4'd2;
      4'd3:    s = 4'd6;
      4'd4:    s = 4'd8;
      4'd5:    s = 4'd1;
      4'd6:    s = 4'd3;
      4'd7:    s = 4'd5;
      default: s = 4'd7;
    endcase
    return s;
  endfunction

  // Board-derived conditions and the square under examination this cycle.
  always_comb begin
    occ     = x | o;
    o_turn  = enable & ~winner & (pop9(x) == (pop9(o) + 4'd1)) & (occ != 9'h1FF);
    accept  = (o & o_move) != 9'h000;
    sq      = (state == SCAN_PREF) ? pref_sq(idx) : idx;
    sq_free = (sq <= 4'd8) ? ~occ[sq] : 1'b0;
  end

  // Next-state, index, hold counter and move register update.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    hold_n   = hold_cnt;
    o_move_n = o_move;
    case (state)
      IDLE: begin
        o_move_n = 9'h000;
        hold_n   = 4'd0;
        idx_n    = 4'd0;
        if (o_turn) state_n = SCAN_WIN;
      end
      SCAN_WIN, SCAN_BLOCK: begin
        if (!o_turn) begin
          state_n  = IDLE;
          idx_n    = 4'd0;
          o_move_n = 9'h000;
        end else if (sq_free && line_hit((state == SCAN_WIN) ? o : x, sq)) begin
          state_n  = PRESENT;
          o_move_n = 9'h001 << sq;
          hold_n   = 4'd0;
        end else if (idx == 4'd8) begin
          state_n = (state == SCAN_WIN) ? SCAN_BLOCK : SCAN_PREF;
          idx_n   = 4'd0;
        end else begin
          idx_n = idx + 4'd1;
        end
      end
      SCAN_PREF: begin
        if (!o_turn) begin
          state_n  = IDLE;
          idx_n    = 4'd0;
          o_move_n = 9'h000;
        end else if (sq_free) begin
          state_n  = PRESENT;
          o_move_n = 9'h001 << sq;
          hold_n   = 4'd0;
        end else if (idx == 4'd8) begin
          state_n  = IDLE;
          idx_n    = 4'd0;
          o_move_n = 9'h000;
        end else begin
          idx_n = idx + 4'd1;
        end
      end
      PRESENT: begin
        // Accept is checked first so a committed move is never counted as an abort.
        if (accept || !o_turn || (hold_cnt == HOLD_LAST)) begin
          state_n  = IDLE;
          idx_n    = 4'd0;
          hold_n   = 4'd0;
          o_move_n = 9'h000;
        end else begin
          hold_n = hold_cnt + 4'd1;
        end
      end
      default: begin
        state_n  = IDLE;
        idx_n    = 4'd0;
        hold_n   = 4'd0;
        o_move_n = 9'h000;
      end
    endcase
  end

  // State, index, hold counter and registered move.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      idx      <= 4'd0;
      hold_cnt <= 4'd0;
      o_move   <= 9'h000;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      hold_cnt <= hold_n;
      o_move   <= o_move_n;
    end
  end

  // Status outputs follow the registered state and move directly.
  always_comb begin
    move_valid = o_move != 9'h000;
    busy       = state != IDLE;
    state_dbg  = state;
  end

`ifdef TTT_OPP_STATS_EN
  // Accepted-move counter, saturating at 9, cleared by an empty board.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      moves_made <= 4'd0;
    end else if (occ == 9'h000) begin
      moves_made <= 4'd0;
    end else if ((state == PRESENT) && accept && (moves_made != 4'd9)) begin
      moves_made <= moves_made + 4'd1;
    end
  end
`endif

endmodule
